// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed ROM, fetch/decode latch.
// Optional stall-cycle counter built only when FETCH_STALL_CNT_EN is defined.
module fetch_stage #(
  parameter int    PC_WIDTH  = 16,
  parameter int    IR_WIDTH  = 32,
  parameter int    IMEM_AW   = 10,
  parameter string IMEM_INIT = "imem.hex"
) (
  input  logic                I_CLOCK,
  input  logic                I_RST_N,
  input  logic                I_LOCK,
  input  logic [PC_WIDTH-1:0] I_BranchPC,
  input  logic                I_BranchAddrSelect,
  input  logic                I_BranchStallSignal,
  input  logic                I_DepStallSignal,
  input  logic                I_GPUStallSignal,
  output logic                O_LOCK,
  output logic [PC_WIDTH-1:0] O_PC,
  output logic [IR_WIDTH-1:0] O_IR,
  output logic                O_FE_Valid,
  output logic [15:0]         O_StallCnt
);

  logic [IR_WIDTH-1:0] imem [2**IMEM_AW];

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] fe_pc_q, fe_pc_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                vld_q, vld_d;
  logic                lock_q;
  logic [PC_WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  // Priority: lock low, redirect, GPU stall, dependency stall, branch stall, fetch.
  always_comb begin
    pc_d    = pc_q;
    fe_pc_d = fe_pc_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    if (!I_LOCK) begin
      vld_d = 1'b0;
    end else if (I_BranchAddrSelect) begin
      pc_d  = I_BranchPC;
      vld_d = 1'b0;
    end else if (I_GPUStallSignal || I_DepStallSignal) begin
      vld_d = vld_q;
    end else if (I_BranchStallSignal) begin
      vld_d = 1'b0;
    end else begin
      ir_d    = imem[pc_q[IMEM_AW+1:2]];
      fe_pc_d = pc_plus4;
      pc_d    = pc_plus4;
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      pc_q    <= '0;
      fe_pc_q <= '0;
      ir_q    <= '0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fe_pc_q <= fe_pc_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
      lock_q  <= I_LOCK;
    end
  end

  assign O_LOCK     = lock_q;
  assign O_PC       = fe_pc_q;
  assign O_IR       = ir_q;
  assign O_FE_Valid = vld_q;

`ifdef FETCH_STALL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q, cnt_d;
  logic        stall_case;

  // Redirect outranks every stall, so a redirect cycle is never counted.
  assign stall_case = I_LOCK && !I_BranchAddrSelect &&
                      (I_GPUStallSignal || I_DepStallSignal || I_BranchStallSignal);

  always_comb begin
    cnt_d = cnt_q;
    if (stall_case) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge I_CLOCK or negedge I_RST_N) begin
    if (!I_RST_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign O_StallCnt = cnt_q;
`else
  assign O_StallCnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a scoreboard queue of expected latch contents.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock, bsel, bst, dep, gpu;
  logic [15:0] bpc;
  logic        o_lock, o_vld;
  logic [15:0] o_pc, o_cnt;
  logic [31:0] o_ir;

  fetch_stage #(.PC_WIDTH(16), .IR_WIDTH(32), .IMEM_AW(10), .IMEM_INIT("")) dut (
    .I_CLOCK            (clk),
    .I_RST_N            (rst_n),
    .I_LOCK             (lock),
    .I_BranchPC         (bpc),
    .I_BranchAddrSelect (bsel),
    .I_BranchStallSignal(bst),
    .I_DepStallSignal   (dep),
    .I_GPUStallSignal   (gpu),
    .O_LOCK             (o_lock),
    .O_PC               (o_pc),
    .O_IR               (o_ir),
    .O_FE_Valid         (o_vld),
    .O_StallCnt         (o_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lock, bsel, bst, dep, gpu;
    logic [15:0] bpc;
    logic        e_vld;
    logic [15:0] e_pc;
    logic [31:0] e_ir;
  } vec_t;

  typedef struct {
    logic        vld, lock;
    logic [15:0] pc, cnt;
    logic [31:0] ir;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic logic [31:0] rom(input int i);
    logic [9:0] idx;
    idx = 10'(i);
    return {16'hC0DE, 6'd0, idx};
  endfunction

  function automatic vec_t mk(input logic l, input logic bs, input logic [15:0] bp,
                              input logic bt, input logic dp, input logic gp,
                              input logic ev, input logic [15:0] ep, input logic [31:0] ei);
    vec_t v;
    v.lock = l; v.bsel = bs; v.bpc = bp; v.bst = bt; v.dep = dp; v.gpu = gp;
    v.e_vld = ev; v.e_pc = ep; v.e_ir = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_vld"},  32'(o_vld),  32'(e.vld));
    chk({tag, "_pc"},   32'(o_pc),   32'(e.pc));
    chk({tag, "_ir"},   o_ir,        e.ir);
    chk({tag, "_lock"}, 32'(o_lock), 32'(e.lock));
    chk({tag, "_cnt"},  32'(o_cnt),  32'(e.cnt));
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    lock = v.lock; bsel = v.bsel; bpc = v.bpc; bst = v.bst; dep = v.dep; gpu = v.gpu;
`ifdef FETCH_STALL_CNT_EN
    if (v.lock && !v.bsel && (v.gpu || v.dep || v.bst)) exp_cnt = exp_cnt + 16'd1;
`endif
    e.vld = v.e_vld; e.pc = v.e_pc; e.ir = v.e_ir; e.lock = v.lock; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) dut.imem[i] = rom(i);
    rst_n = 1'b0; lock = 1'b0; bsel = 1'b0; bpc = '0; bst = 1'b0; dep = 1'b0; gpu = 1'b0;

    //            L  BS BPC       BST DEP GPU  vld pc        ir
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h0004, rom(0)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h0008, rom(1)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0,  1, 16'h0008, rom(1)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0,  1, 16'h0008, rom(1)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h000C, rom(2)));
    vecs.push_back(mk(1, 1, 16'h0040, 0, 1, 0,  0, 16'h000C, rom(2)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h0044, rom(16)));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0,  0, 16'h0044, rom(16)));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0,  0, 16'h0044, rom(16)));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0,  0, 16'h0044, rom(16)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h0048, rom(17)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1,  1, 16'h0048, rom(17)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1,  1, 16'h0048, rom(17)));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0,  0, 16'h0048, rom(17)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1,  0, 16'h0048, rom(17)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h004C, rom(18)));
    vecs.push_back(mk(1, 1, 16'h0FFE, 0, 0, 1,  0, 16'h004C, rom(18)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h1002, rom(1023)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h1006, rom(0)));
    vecs.push_back(mk(1, 1, 16'hFFFC, 1, 0, 0,  0, 16'h1006, rom(0)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h0000, rom(1023)));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0,  1, 16'h0004, rom(0)));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld",  32'(o_vld),  32'd0);
    chk("reset_pc",   32'(o_pc),   32'd0);
    chk("reset_ir",   o_ir,        32'd0);
    chk("reset_lock", 32'(o_lock), 32'd0);
    chk("reset_cnt",  32'(o_cnt),  32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset asserted mid dependency stall.
    @(negedge clk);
    lock = 1'b1; dep = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld",  32'(o_vld),  32'd0);
    chk("arst_pc",   32'(o_pc),   32'd0);
    chk("arst_ir",   o_ir,        32'd0);
    chk("arst_lock", 32'(o_lock), 32'd0);
    chk("arst_cnt",  32'(o_cnt),  32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_vld", 32'(o_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    apply(mk(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0004, rom(0)), "restart0");
    apply(mk(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0008, rom(1)), "restart1");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
